core_select_switch: RTL and testbench

- Parametrised selector between NUM_CORES independent computer cores that sit side by side under the top-level emu.
- Takes a requested core index from the OSD status and routes the active core's video, SD-SPI, UART and LED signals to the platform.
- On a selection change it runs a sequenced switch: blank the output, hold every core in reset for a fixed time, then release only the new core.
- Replaces a purely combinational index mux with glitch-free, reset-sequenced switching.

---
 rtl/core_select_switch.sv | 191 +++++++++++++++++++
 tb/tb_core_select_switch.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/core_select_switch.sv
// Glitch-free selector between NUM_CORES cores: blanks output, holds all cores in reset, releases the new one.
// Optional CORE_CE_GATE_EN: per-core clock enable follows the released core instead of being constant all-ones.
module core_select_switch #(
  parameter int NUM_CORES = 4,
  parameter int SEL_W     = 2,
  parameter int RGB_W     = 2,
  parameter int BLANK_TMO = 2000000,
  parameter int RST_HOLD  = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SEL_W-1:0]           sel_req,
  input  logic [NUM_CORES*RGB_W-1:0] core_r,
  input  logic [NUM_CORES*RGB_W-1:0] core_g,
  input  logic [NUM_CORES*RGB_W-1:0] core_b,
  input  logic [NUM_CORES-1:0]       core_hs,
  input  logic [NUM_CORES-1:0]       core_vs,
  input  logic [NUM_CORES-1:0]       core_hblank,
  input  logic [NUM_CORES-1:0]       core_vblank,
  input  logic [NUM_CORES-1:0]       core_ce_pix,
  input  logic [NUM_CORES-1:0]       core_sd_cs,
  input  logic [NUM_CORES-1:0]       core_sd_mosi,
  input  logic [NUM_CORES-1:0]       core_sd_sck,
  input  logic [NUM_CORES-1:0]       core_txd,
  input  logic [NUM_CORES-1:0]       core_rts,
  input  logic [NUM_CORES-1:0]       core_led,
  output logic [NUM_CORES-1:0]       core_reset_n,
  output logic [NUM_CORES-1:0]       core_ce,
  output logic [RGB_W-1:0]           r,
  output logic [RGB_W-1:0]           g,
  output logic [RGB_W-1:0]           b,
  output logic                       hs,
  output logic                       vs,
  output logic                       hblank,
  output logic                       vblank,
  output logic                       ce_pix,
  output logic                       sd_cs,
  output logic                       sd_mosi,
  output logic                       sd_sck,
  output logic                       uart_txd,
  output logic                       uart_rts,
  output logic                       drive_led,
  output logic [SEL_W-1:0]           active_sel,
  output logic                       switching
);

  localparam int CNT_MAX = (BLANK_TMO > RST_HOLD) ? BLANK_TMO : RST_HOLD;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [SEL_W:0] NUM_CORES_W = (SEL_W+1)'(NUM_CORES);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN, BLANK} state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [SEL_W-1:0]       target_q, active_sel_q;
  logic [NUM_CORES-1:0]   core_reset_n_q;
  logic [RGB_W-1:0]       r_q, g_q, b_q;
  logic                   hs_q, vs_q, hblank_q, vblank_q, ce_pix_q;
  logic                   sd_cs_q, sd_mosi_q, sd_sck_q, txd_q, rts_q, led_q;
  logic                   switching_q, vbl_prev_q;

  logic [RGB_W-1:0]       sel_r_d, sel_g_d, sel_b_d;
  logic                   sel_hs_d, sel_vs_d, sel_hblank_d, sel_vblank_d, sel_ce_pix_d;
  logic                   sel_sd_cs_d, sel_sd_mosi_d, sel_sd_sck_d, sel_txd_d, sel_rts_d, sel_led_d;
  logic [NUM_CORES-1:0]   oh_target_d;
  logic                   req_valid_d, vbl_rise_d;

  always_comb begin
    sel_r_d = '0; sel_g_d = '0; sel_b_d = '0;
    sel_hs_d = 1'b0; sel_vs_d = 1'b0; sel_hblank_d = 1'b1; sel_vblank_d = 1'b1; sel_ce_pix_d = 1'b0;
    sel_sd_cs_d = 1'b1; sel_sd_mosi_d = 1'b0; sel_sd_sck_d = 1'b0;
    sel_txd_d = 1'b1; sel_rts_d = 1'b1; sel_led_d = 1'b0;
    oh_target_d = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (active_sel_q == SEL_W'(i)) begin
        sel_r_d       = core_r[i*RGB_W +: RGB_W];
        sel_g_d       = core_g[i*RGB_W +: RGB_W];
        sel_b_d       = core_b[i*RGB_W +: RGB_W];
        sel_hs_d      = core_hs[i];
        sel_vs_d      = core_vs[i];
        sel_hblank_d  = core_hblank[i];
        sel_vblank_d  = core_vblank[i];
        sel_ce_pix_d  = core_ce_pix[i];
        sel_sd_cs_d   = core_sd_cs[i];
        sel_sd_mosi_d = core_sd_mosi[i];
        sel_sd_sck_d  = core_sd_sck[i];
        sel_txd_d     = core_txd[i];
        sel_rts_d     = core_rts[i];
        sel_led_d     = core_led[i];
      end
      if (target_q == SEL_W'(i)) oh_target_d[i] = 1'b1;
    end
    req_valid_d = {1'b0, sel_req} < NUM_CORES_W;
    vbl_rise_d  = !vbl_prev_q && sel_vblank_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= HOLD;
      cnt_q          <= '0;
      target_q       <= req_valid_d ? sel_req : '0;
      active_sel_q   <= '0;
      core_reset_n_q <= '0;
      r_q <= '0; g_q <= '0; b_q <= '0;
      hs_q <= 1'b0; vs_q <= 1'b0; hblank_q <= 1'b1; vblank_q <= 1'b1; ce_pix_q <= 1'b0;
      sd_cs_q <= 1'b1; sd_mosi_q <= 1'b0; sd_sck_q <= 1'b0;
      txd_q <= 1'b1; rts_q <= 1'b1; led_q <= 1'b0;
      switching_q    <= 1'b1;
      vbl_prev_q     <= 1'b0;
    end else begin
      // Idle values by default; RUN overrides, BLANK re-enables the sync signals.
      r_q <= '0; g_q <= '0; b_q <= '0;
      hs_q <= 1'b0; vs_q <= 1'b0; hblank_q <= 1'b1; vblank_q <= 1'b1; ce_pix_q <= 1'b0;
      sd_cs_q <= 1'b1; sd_mosi_q <= 1'b0; sd_sck_q <= 1'b0;
      txd_q <= 1'b1; rts_q <= 1'b1; led_q <= 1'b0;
      switching_q <= 1'b1;
      vbl_prev_q  <= sel_vblank_d;
      case (state_q)
        HOLD: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(RST_HOLD-1)) begin
            cnt_q          <= '0;
            active_sel_q   <= target_q;
            core_reset_n_q <= oh_target_d;
            state_q        <= RELEASE;
          end
        end
        RELEASE: begin
          state_q     <= RUN;
          switching_q <= 1'b0;
          r_q <= sel_r_d; g_q <= sel_g_d; b_q <= sel_b_d;
          hs_q <= sel_hs_d; vs_q <= sel_vs_d; hblank_q <= sel_hblank_d;
          vblank_q <= sel_vblank_d; ce_pix_q <= sel_ce_pix_d;
          sd_cs_q <= sel_sd_cs_d; sd_mosi_q <= sel_sd_mosi_d; sd_sck_q <= sel_sd_sck_d;
          txd_q <= sel_txd_d; rts_q <= sel_rts_d; led_q <= sel_led_d;
        end
        RUN: begin
          if (req_valid_d && sel_req != active_sel_q) begin
            target_q <= sel_req;
            cnt_q    <= '0;
            state_q  <= BLANK;
            hs_q <= sel_hs_d; vs_q <= sel_vs_d; ce_pix_q <= sel_ce_pix_d;
          end else begin
            switching_q <= 1'b0;
            r_q <= sel_r_d; g_q <= sel_g_d; b_q <= sel_b_d;
            hs_q <= sel_hs_d; vs_q <= sel_vs_d; hblank_q <= sel_hblank_d;
            vblank_q <= sel_vblank_d; ce_pix_q <= sel_ce_pix_d;
            sd_cs_q <= sel_sd_cs_d; sd_mosi_q <= sel_sd_mosi_d; sd_sck_q <= sel_sd_sck_d;
            txd_q <= sel_txd_d; rts_q <= sel_rts_d; led_q <= sel_led_d;
          end
        end
        BLANK: begin
          cnt_q <= cnt_q + 1'b1;
          if (vbl_rise_d || cnt_q == CNT_W'(BLANK_TMO-1)) begin
            cnt_q          <= '0;
            core_reset_n_q <= '0;
            state_q        <= HOLD;
          end else begin
            hs_q <= sel_hs_d; vs_q <= sel_vs_d; ce_pix_q <= sel_ce_pix_d;
          end
        end
        default: state_q <= HOLD;
      endcase
    end
  end

  assign core_reset_n = core_reset_n_q;
`ifdef CORE_CE_GATE_EN
  // The enable pattern is exactly the released core's one-hot reset pattern.
  assign core_ce = core_reset_n_q;
`else
  assign core_ce = '1;
`endif
  assign r          = r_q;
  assign g          = g_q;
  assign b          = b_q;
  assign hs         = hs_q;
  assign vs         = vs_q;
  assign hblank     = hblank_q;
  assign vblank     = vblank_q;
  assign ce_pix     = ce_pix_q;
  assign sd_cs      = sd_cs_q;
  assign sd_mosi    = sd_mosi_q;
  assign sd_sck     = sd_sck_q;
  assign uart_txd   = txd_q;
  assign uart_rts   = rts_q;
  assign drive_led  = led_q;
  assign active_sel = active_sel_q;
  assign switching  = switching_q;

endmodule

// File: tb/tb_core_select_switch.sv
// Directed bench for core_select_switch: reset hold, release, vblank and timeout switches, mid-HOLD reset.
module tb_core_select_switch;
  localparam int NC = 4, SW = 3, RW = 2, TMO = 100, RH = 16;

  logic clk, reset;
  logic [SW-1:0] sel_req;
  logic [NC*RW-1:0] core_r, core_g, core_b;
  logic [NC-1:0] core_hs, core_vs, core_hblank, core_vblank, core_ce_pix;
  logic [NC-1:0] core_sd_cs, core_sd_mosi, core_sd_sck, core_txd, core_rts, core_led;
  logic [NC-1:0] core_reset_n, core_ce;
  logic [RW-1:0] r, g, b;
  logic hs, vs, hblank, vblank, ce_pix, sd_cs, sd_mosi, sd_sck, uart_txd, uart_rts, drive_led;
  logic [SW-1:0] active_sel;
  logic switching;

  int n_tests = 0;
  int n_fail  = 0;

  core_select_switch #(.NUM_CORES(NC), .SEL_W(SW), .RGB_W(RW), .BLANK_TMO(TMO), .RST_HOLD(RH)) dut (
    .clk(clk), .reset(reset), .sel_req(sel_req),
    .core_r(core_r), .core_g(core_g), .core_b(core_b),
    .core_hs(core_hs), .core_vs(core_vs), .core_hblank(core_hblank), .core_vblank(core_vblank),
    .core_ce_pix(core_ce_pix), .core_sd_cs(core_sd_cs), .core_sd_mosi(core_sd_mosi),
    .core_sd_sck(core_sd_sck), .core_txd(core_txd), .core_rts(core_rts), .core_led(core_led),
    .core_reset_n(core_reset_n), .core_ce(core_ce), .r(r), .g(g), .b(b),
    .hs(hs), .vs(vs), .hblank(hblank), .vblank(vblank), .ce_pix(ce_pix),
    .sd_cs(sd_cs), .sd_mosi(sd_mosi), .sd_sck(sd_sck), .uart_txd(uart_txd), .uart_rts(uart_rts),
    .drive_led(drive_led), .active_sel(active_sel), .switching(switching)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // core i: r=i, g=3-i, b=i^1
    core_r = 8'hE4; core_g = 8'h1B; core_b = 8'hB1;
    core_hs = 4'b0110; core_vs = 4'b0010; core_hblank = 4'b0000; core_vblank = 4'b0000;
    core_ce_pix = 4'b0010; core_sd_cs = 4'b0101; core_sd_mosi = 4'b0010; core_sd_sck = 4'b0000;
    core_txd = 4'b1001; core_rts = 4'b0001; core_led = 4'b1010;
    reset = 1'b1; sel_req = 3'd1;
    tick(3);
    chk("rst_switching", switching, 1);
    chk("rst_core_reset_n", core_reset_n, 0);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_blank", {hblank, vblank, hs, vs}, 4'b1100);
    chk("rst_periph", {sd_cs, sd_mosi, sd_sck, uart_txd, uart_rts, drive_led}, 6'b100110);
    chk("rst_active_sel", active_sel, 0);
`ifdef CORE_CE_GATE_EN
    chk("rst_core_ce", core_ce, 4'b0000);
`endif

    reset = 1'b0;
    for (int i = 1; i < RH; i++) begin
      tick(1);
      chk("hold1_rstn", core_reset_n, 0);
      chk("hold1_switching", switching, 1);
    end
    tick(1);
    chk("rel1_rstn", core_reset_n, 4'b0010);
    chk("rel1_active_sel", active_sel, 1);
    tick(1);
    chk("run1_switching", switching, 0);
    chk("run1_rgb", {r, g, b}, 6'b01_10_00);
    chk("run1_timing", {hs, vs, hblank, vblank, ce_pix}, 5'b11001);
    chk("run1_periph", {sd_cs, sd_mosi, uart_txd, uart_rts, drive_led}, 5'b01001);

    core_r = 8'hEC;
    chk("lat_before_edge", r, 1);
    tick(1);
    chk("lat_after_edge", r, 3);
    core_r = 8'hE4;

    sel_req = 3'd5;
    tick(4);
    chk("oor_switching", switching, 0);
    chk("oor_active_sel", active_sel, 1);
    chk("oor_rstn", core_reset_n, 4'b0010);

    sel_req = 3'd2;
    tick(1);
    chk("blank_switching", switching, 1);
    chk("blank_rgb", {r, g, b}, 0);
    chk("blank_sync", {hblank, vblank, hs, ce_pix}, 4'b1111);
    chk("blank_periph", {sd_cs, uart_txd, drive_led}, 3'b110);
    chk("blank_rstn", core_reset_n, 4'b0010);
    tick(3);
    chk("blank_wait_rstn", core_reset_n, 4'b0010);
    core_vblank = 4'b0010;
    tick(1);
    chk("vbl_hold_rstn", core_reset_n, 0);
    chk("vbl_hold_sync", {hs, vs, ce_pix}, 0);
    core_vblank = 4'b0000;
    sel_req = 3'd3;
    for (int i = 1; i < RH; i++) tick(1);
    chk("hold2_rstn", core_reset_n, 0);
    tick(1);
    chk("rel2_rstn", core_reset_n, 4'b0100);
    chk("rel2_active_sel", active_sel, 2);
    tick(1);
    chk("run2_switching", switching, 0);
    chk("run2_rgb", {r, g, b}, 6'b10_01_11);
`ifdef CORE_CE_GATE_EN
    chk("run2_core_ce", core_ce, 4'b0100);
`endif
    tick(1);
    chk("resw_switching", switching, 1);
    for (int i = 1; i < TMO; i++) tick(1);
    chk("tmo_pre_rstn", core_reset_n, 4'b0100);
    tick(1);
    chk("tmo_hold_rstn", core_reset_n, 0);
`ifdef CORE_CE_GATE_EN
    chk("hold_core_ce", core_ce, 4'b0000);
`endif

    tick(10);
    reset = 1'b1;
    tick(1);
    chk("midrst_active_sel", active_sel, 0);
    reset = 1'b0;
    for (int i = 1; i < RH; i++) tick(1);
    chk("hold3_rstn", core_reset_n, 0);
    tick(1);
    chk("rel3_rstn", core_reset_n, 4'b1000);
    chk("rel3_active_sel", active_sel, 3);
    tick(1);
    chk("run3_rgb", {r, g, b}, 6'b11_00_10);
    chk("run3_periph", {sd_cs, uart_txd, drive_led}, 3'b011);
    chk("run3_switching", switching, 0);
`ifdef CORE_CE_GATE_EN
    chk("run3_core_ce", core_ce, 4'b1000);
`else
    chk("core_ce_ones", core_ce, 4'b1111);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
